// File: rtl/bram_load_sequencer.sv
// bram_load_sequencer
// Steers one valid/ready word stream from the PS into four BRAM write ports,
// filling weight, a, node-info and H-data memories in that order.
// Every memory is written from address 0 upward, and each memory gets a
// sticky load_done flag.
//
// Ports
//   clk, rst_n           clock; synchronous reset, active-high (1 = reset)
//   start                one-cycle pulse: latch counts, begin a sequence
//   cfg_*_cnt            words per memory (clamped to 2^ADDR_W)
//   s_vld/s_data/s_rdy   input word stream
//   wr_din/wr_addr       shared BRAM write data/address
//   *_ena                one-hot write enables
//   *_load_done          sticky per-memory done flags
//   busy                 a load region is active
//   all_done             one-cycle pulse after the final region completes
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start, stream not accepted
// ST_WGT   | loading weight BRAM
// ST_A     | loading attention-vector BRAM
// ST_INFO  | loading node-info BRAM
// ST_HDATA | loading H-data BRAM
// ST_FIN   | sequence complete, all_done is issued on the exit edge
module bram_load_sequencer #(
  parameter int DIN_W  = 64,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_wgt_cnt,
  input  logic [CNT_W-1:0]  cfg_a_cnt,
  input  logic [CNT_W-1:0]  cfg_info_cnt,
  input  logic [CNT_W-1:0]  cfg_hdata_cnt,
  input  logic              s_vld,
  input  logic [DIN_W-1:0]  s_data,
  output logic              s_rdy,
  output logic [DIN_W-1:0]  wr_din,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wgt_ena,
  output logic              a_ena,
  output logic              info_ena,
  output logic              hdata_ena,
  output logic              wgt_load_done,
  output logic              a_load_done,
  output logic              info_load_done,
  output logic              hdata_load_done,
  output logic              busy,
  output logic              all_done
);

  // Load state encoding is region index + 1, so ST_FIN doubles as
  // "region 4 = no region left".
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WGT   = 3'd1,
    ST_A     = 3'd2,
    ST_INFO  = 3'd3,
    ST_HDATA = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(1) << ADDR_W;
  localparam logic [2:0]       NO_REGION = 3'd4;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt_q  [4];
  logic [CNT_W-1:0]  cfg_in [4];
  logic [3:0]        ena_q;
  logic [3:0]        done_q;
  logic [3:0]        nz_cfg;
  logic [3:0]        nz_q;
  logic [2:0]        cur;
  logic [2:0]        first_cfg;
  logic [2:0]        next_reg;
  logic              last_beat;
  logic              loading;

  // First region at or after 'from' with a nonzero count, else NO_REGION.
  function automatic logic [2:0] next_from(input logic [2:0] from, input logic [3:0] nz);
    logic [2:0] r;
    r = NO_REGION;
    for (int k = 3; k >= 0; k--) begin
      if ((3'(k) >= from) && nz[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Regions lo..hi-1: the one just finished plus any zero-count regions skipped.
  function automatic logic [3:0] span_mask(input logic [2:0] lo, input logic [2:0] hi);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) >= lo) && (3'(k) < hi)) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  assign cfg_in[0] = cfg_wgt_cnt;
  assign cfg_in[1] = cfg_a_cnt;
  assign cfg_in[2] = cfg_info_cnt;
  assign cfg_in[3] = cfg_hdata_cnt;

  always_comb begin
    nz_cfg = '0;
    nz_q   = '0;
    for (int k = 0; k < 4; k++) begin
      nz_cfg[k] = (cfg_in[k] != '0);
      nz_q[k]   = (cnt_q[k] != '0);
    end
  end

  assign cur       = 3'(state) - 3'd1;
  assign first_cfg = next_from(3'd0, nz_cfg);
  assign next_reg  = next_from(cur + 3'd1, nz_q);
  // Counts are clamped, so the last index of a full region is 2^ADDR_W-1
  // and idx never needs to wrap.
  assign last_beat = (CNT_W'(idx) == (cnt_q[cur[1:0]] - CNT_W'(1)));
  assign loading   = (state == ST_WGT) || (state == ST_A) ||
                     (state == ST_INFO) || (state == ST_HDATA);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      done_q   <= '0;
      ena_q    <= '0;
      wr_din   <= '0;
      wr_addr  <= '0;
      all_done <= 1'b0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      ena_q    <= '0;
      all_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= clamp_cnt(cfg_in[k]);
            // Leading zero-count regions are complete before any beat.
            done_q <= span_mask(3'd0, first_cfg);
            idx    <= '0;
            state  <= state_t'(first_cfg + 3'd1);
          end
        end
        ST_WGT, ST_A, ST_INFO, ST_HDATA: begin
          if (s_vld) begin
            wr_din  <= s_data;
            wr_addr <= idx;
            ena_q   <= 4'b0001 << cur[1:0];
            if (last_beat) begin
              idx    <= '0;
              done_q <= done_q | span_mask(cur, next_reg);
              state  <= state_t'(next_reg + 3'd1);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_FIN: begin
          all_done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_rdy           = loading;
  assign busy            = loading;
  assign wgt_ena         = ena_q[0];
  assign a_ena           = ena_q[1];
  assign info_ena        = ena_q[2];
  assign hdata_ena       = ena_q[3];
  assign wgt_load_done   = done_q[0];
  assign a_load_done     = done_q[1];
  assign info_load_done  = done_q[2];
  assign hdata_load_done = done_q[3];

endmodule

// File: doc/bram_load_sequencer.md
Name: bram_load_sequencer

Overview:
- Sequences the PS-to-PL initialization of the four input memories: weight BRAM, attention-vector (a) BRAM, node-info BRAM and H-data BRAM.
- Accepts one valid/ready word stream from the PS side.
- Steers each word to the correct BRAM write port with auto-incrementing addresses.
- Raises the per-memory load_done flags consumed by the compute pipeline.

Parameters:
- DIN_W, 64, stream/write data width (narrower BRAMs take the LSBs).
- ADDR_W, 16, BRAM write address width.
- CNT_W, 17, width of word-count configuration inputs (ADDR_W+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-high (1 = reset).
- start  in  1  single-cycle pulse; latches counts and begins a load sequence.
- cfg_wgt_cnt  in  CNT_W  words for weight BRAM.
- cfg_a_cnt  in  CNT_W  words for a BRAM.
- cfg_info_cnt  in  CNT_W  words for node-info BRAM.
- cfg_hdata_cnt  in  CNT_W  words for H-data BRAM.
- s_vld  in  1  stream word valid.
- s_data  in  DIN_W  stream word.
- s_rdy  out  1  sequencer can accept a word.
- wr_din  out  DIN_W  shared BRAM write data.
- wr_addr  out  ADDR_W  shared BRAM write address.
- wgt_ena, a_ena, info_ena, hdata_ena  out  1 each  one-hot write enables.
- wgt_load_done, a_load_done, info_load_done, hdata_load_done  out  1 each  sticky per-memory done.
- busy  out  1  sequence in progress.
- all_done  out  1  single-cycle pulse when the final region completes.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-sequence aborts immediately. No enable asserts in the cycle after reset. Done flags clear.
- States: IDLE, WGT, A, INFO, HDATA, FIN.
- IDLE: s_rdy=0, busy=0.
  - On start: latch the four counts, clear all four done flags, go to the first region with nonzero count, in order WGT, A, INFO, HDATA.
  - If all counts are 0: go to FIN.
- Count clamping: a count greater than 2^ADDR_W is clamped to 2^ADDR_W at latch.
- Load states: s_rdy=1 and busy=1.
  - A beat is accepted when s_vld & s_rdy.
  - On each beat, the next cycle has: wr_din=s_data, wr_addr=current word index, and only the region's ena=1. Latency from beat to write is 1 cycle.
  - Without a beat, all enas are 0 and wr_din/wr_addr hold their values.
- Region completion: on the beat that is the region's last word (index = cnt-1):
  - The region's done flag sets in the same cycle as its final ena.
  - The word index resets to 0.
  - The state advances to the next nonzero region, or to FIN; zero-count regions are skipped.
  - The skipped regions' done flags set on that same transition.
  - s_rdy stays 1 across the region boundary, so back-to-back beats cross regions with no bubble.
- Address wrap: at index 2^ADDR_W-1 the region always completes, given the clamp.
- FIN: all_done=1 for one cycle, busy=0, s_rdy=0. The next state is IDLE.
- Done flags: remain set until the next start or reset.
- start while busy: ignored. Counts are not re-latched and the sequence continues.
- s_vld in IDLE/FIN: not accepted (s_rdy=0); data is not consumed.
- Done-flag timing: each done flag is registered. It first reads 1 in the cycle where the final write for that region is presented on the BRAM port, so a downstream reader sampling done on the next edge sees the data written.
- Fixed region order; no arbitration between regions.

Test Plan:
- Basic sequence: counts wgt=4, a=2, info=3, hdata=5; stream 14 words with s_vld held high, values 0..13.
  - 14 consecutive write cycles, no gaps.
  - wgt_ena at addr 0..3 with data 0..3; a_ena at addr 0..1 with 4..5; info_ena at addr 0..2 with 6..8; hdata_ena at addr 0..4 with 9..13.
  - Each done flag rises with its last write.
  - all_done pulses 1 cycle after the last write; busy then 0.
- Zero-count skip: counts wgt=0, a=1, info=0, hdata=2; 3 words.
  - First write on a_ena addr 0.
  - wgt_load_done=1 from the first load cycle.
  - info_load_done sets when a's last beat is accepted.
  - Then hdata addr 0..1.
- All-zero counts: start.
  - FIN in the next cycle, all four done flags=1, all_done pulse, no ena ever asserted, s_rdy never 1.
- Backpressure and gaps: counts wgt=3, others 0; s_vld pattern 1,0,0,1,0,1.
  - Writes occur only after each accepted beat, at addr 0, 1, 2.
  - Address holds during gaps.
  - wgt_load_done with the third write.
- Illegal start and mid-sequence reset: start again after 2 of 4 wgt words.
  - The start is ignored; the sequence completes normally.
  - Then assert rst_n=1 after 1 word of a new sequence: all outputs 0 the next cycle, done flags cleared, s_rdy=0 until a new start.
- Clamp and wrap: ADDR_W=4, cfg_wgt_cnt=20.
  - Exactly 16 writes at addr 0..15, then wgt_load_done.
  - The 17th beat goes to the next nonzero region, or is not accepted if none remain.
